mux_sel_scheduler: RTL

Controller that drives the select line of the LED 2:1 mux, which chooses between the 1 Hz and 5 Hz blink sources. It takes the select from a debounced slide switch in manual mode, or toggles it on a fixed dwell period in auto mode. Every select change is deferred until both mux inputs are low, so the LED never shows a runt pulse. A timeout forces the change if that safe point never arrives. The block sits between the board switches and the mux `sel` pin, in the `CLOCK_50` domain.

---
 rtl/mux_sel_scheduler.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mux_sel_scheduler.sv
// Drives the LED mux select from a debounced manual switch or an auto dwell timer, deferring each change to a both-inputs-low point.
// Latency: 2 cycles from target mismatch to sel update at best, timeout bounds the wait; no backpressure, sel_changed/forced are 1-cycle pulses.
module mux_sel_scheduler #(
    parameter int unsigned DEBOUNCE_CYCLES  = 1_000_000,
    parameter int unsigned DWELL_CYCLES     = 150_000_000,
    parameter int unsigned HANDOVER_TIMEOUT = 50_000_000
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic i0,
    input  logic i1,
    input  logic mode_sw,
    input  logic sel_sw,
    output logic sel,
    output logic switching,
    output logic sel_changed,
    output logic forced
);

    localparam logic [31:0] DEB_LAST   = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);
    localparam logic [31:0] TMO_LAST   = 32'(HANDOVER_TIMEOUT - 1);

    typedef enum logic {ST_HOLD, ST_WAIT} state_t;

    logic        mode_s1_q, mode_s2_q, mode_db_q;
    logic        sel_s1_q, sel_s2_q, sel_db_q;
    logic [31:0] mode_cnt_q, sel_cnt_q;
    logic        mode_upd, sel_upd;

    logic [31:0] dwell_q;
    logic [31:0] tmo_q;
    state_t      state_q;
    logic        sel_q, switching_q, sel_changed_q, forced_q;

    logic        target;
    logic        safe_pt;
    logic        commit;

    assign mode_upd = (mode_s2_q != mode_db_q) && (mode_cnt_q == DEB_LAST);
    assign sel_upd  = (sel_s2_q != sel_db_q) && (sel_cnt_q == DEB_LAST);

    // Synchronizers and debouncers for both slide switches
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            mode_s1_q  <= 1'b0;
            mode_s2_q  <= 1'b0;
            mode_db_q  <= 1'b0;
            mode_cnt_q <= '0;
            sel_s1_q   <= 1'b0;
            sel_s2_q   <= 1'b0;
            sel_db_q   <= 1'b0;
            sel_cnt_q  <= '0;
        end else begin
            mode_s1_q <= mode_sw;
            mode_s2_q <= mode_s1_q;
            sel_s1_q  <= sel_sw;
            sel_s2_q  <= sel_s1_q;

            if (mode_s2_q == mode_db_q) begin
                mode_cnt_q <= '0;
            end else if (mode_upd) begin
                mode_db_q  <= mode_s2_q;
                mode_cnt_q <= '0;
            end else begin
                mode_cnt_q <= mode_cnt_q + 32'd1;
            end

            if (sel_s2_q == sel_db_q) begin
                sel_cnt_q <= '0;
            end else if (sel_upd) begin
                sel_db_q  <= sel_s2_q;
                sel_cnt_q <= '0;
            end else begin
                sel_cnt_q <= sel_cnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        target = sel_q;
        if (!mode_db_q) begin
            target = sel_db_q;
        end else if (dwell_q == DWELL_LAST) begin
            target = ~sel_q;
        end
    end

    assign safe_pt = !i0 && !i1;
    assign commit  = (state_q == ST_WAIT) && (target != sel_q)
                     && (safe_pt || (tmo_q == TMO_LAST));

    // Dwell only advances while holding in auto mode; it parks at its last value until the toggle commits
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            dwell_q <= '0;
        end else if (mode_upd || commit) begin
            dwell_q <= '0;
        end else if (mode_db_q && (state_q == ST_HOLD) && (dwell_q != DWELL_LAST)) begin
            dwell_q <= dwell_q + 32'd1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= ST_HOLD;
            sel_q         <= 1'b0;
            switching_q   <= 1'b0;
            sel_changed_q <= 1'b0;
            forced_q      <= 1'b0;
            tmo_q         <= '0;
        end else begin
            sel_changed_q <= 1'b0;
            forced_q      <= 1'b0;
            case (state_q)
                ST_HOLD: begin
                    if (target != sel_q) begin
                        state_q     <= ST_WAIT;
                        switching_q <= 1'b1;
                        tmo_q       <= '0;
                    end
                end
                ST_WAIT: begin
                    // Abort wins over commit when the request is withdrawn
                    if (target == sel_q) begin
                        state_q     <= ST_HOLD;
                        switching_q <= 1'b0;
                    end else if (safe_pt || (tmo_q == TMO_LAST)) begin
                        state_q       <= ST_HOLD;
                        switching_q   <= 1'b0;
                        sel_q         <= ~sel_q;
                        sel_changed_q <= 1'b1;
                        forced_q      <= !safe_pt;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                default: begin
                    state_q     <= ST_HOLD;
                    switching_q <= 1'b0;
                end
            endcase
        end
    end

    assign sel         = sel_q;
    assign switching   = switching_q;
    assign sel_changed = sel_changed_q;
    assign forced      = forced_q;

endmodule
